// File: rtl/opb_master_arbiter.sv
// Purpose : round-robin arbiter sharing one OPB register bus between M0 (host bridge) and M1 (DMA engine).
// Latency : write strobe 1 cycle after the REQ sample edge, ACK 2 cycles after; read ACK+RDATA 3 cycles after.
// Backpr. : requesters hold REQ until their ACK pulse; only REQs seen in IDLE are arbitrated.
//
// Ports
//   OPB_CLK, OPB_RST          clock, synchronous active-high reset
//   Mx_REQ/RNW/ADDR/WDATA     requester x command (held stable while REQ is high)
//   Mx_ACK, Mx_RDATA          requester x one-cycle completion pulse and read data
//   Mx_LOCK                   requester x bus lock (only when OPB_ARB_LOCK_EN is defined)
//   OPB_RE/WE/ADDR/DI, OPB_DO OPB master side; OPB_DO is valid the cycle after OPB_RE
//   BUSY, GRANT_ID            transaction in flight, current/last granted master
//
// Optional feature: define OPB_ARB_LOCK_EN to add M0_LOCK/M1_LOCK for atomic
// read-modify-write sequences; when undefined the arbiter is pure round-robin.

module opb_master_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              OPB_CLK,
    input  logic              OPB_RST,
    input  logic              M0_REQ,
    input  logic              M0_RNW,
    input  logic [ADDR_W-1:0] M0_ADDR,
    input  logic [DATA_W-1:0] M0_WDATA,
    output logic              M0_ACK,
    output logic [DATA_W-1:0] M0_RDATA,
    input  logic              M1_REQ,
    input  logic              M1_RNW,
    input  logic [ADDR_W-1:0] M1_ADDR,
    input  logic [DATA_W-1:0] M1_WDATA,
    output logic              M1_ACK,
    output logic [DATA_W-1:0] M1_RDATA,
`ifdef OPB_ARB_LOCK_EN
    input  logic              M0_LOCK,
    input  logic              M1_LOCK,
`endif
    output logic              OPB_RE,
    output logic              OPB_WE,
    output logic [ADDR_W-1:0] OPB_ADDR,
    output logic [DATA_W-1:0] OPB_DI,
    input  logic [DATA_W-1:0] OPB_DO,
    output logic              BUSY,
    output logic              GRANT_ID
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_grant;     // master owning the current/last transaction
    logic                r_last;      // round-robin pointer: master granted last
    logic                r_cmd_rnw;
    logic                r_opb_re;
    logic                r_opb_we;
    logic [ADDR_W-1:0]   r_opb_addr;
    logic [DATA_W-1:0]   r_opb_di;
    logic                r_m0_ack;
    logic                r_m1_ack;
    logic [DATA_W-1:0]   r_m0_rdata;
    logic [DATA_W-1:0]   r_m1_rdata;

    // Arbitration candidates after lock masking
    logic                w_cand0;
    logic                w_cand1;
    logic                w_any;
    logic                w_win;
    logic                w_sel_rnw;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

`ifdef OPB_ARB_LOCK_EN
    logic                r_locked;
    logic                r_lock_own;
    logic                w_owner_lock;
    logic                w_lock_hold;
    logic                w_grant_lock;

    assign w_owner_lock = r_lock_own ? M1_LOCK : M0_LOCK;
    // Lock only masks the other master while the owner still asserts LOCK;
    // a low LOCK in IDLE releases it and plain round-robin applies that cycle.
    assign w_lock_hold  = r_locked && w_owner_lock;
    assign w_grant_lock = r_grant ? M1_LOCK : M0_LOCK;
    assign w_cand0      = M0_REQ && !(w_lock_hold && r_lock_own);
    assign w_cand1      = M1_REQ && !(w_lock_hold && !r_lock_own);
`else
    assign w_cand0      = M0_REQ;
    assign w_cand1      = M1_REQ;
`endif

    assign w_any       = w_cand0 || w_cand1;
    // On a tie the master that was not granted last wins
    assign w_win       = (w_cand0 && w_cand1) ? ~r_last : w_cand1;
    assign w_sel_rnw   = w_win ? M1_RNW   : M0_RNW;
    assign w_sel_addr  = w_win ? M1_ADDR  : M0_ADDR;
    assign w_sel_wdata = w_win ? M1_WDATA : M0_WDATA;

    // The bus-side address/data registers are loaded at grant and act as the
    // command latch; they are cleared after the single ISSUE cycle so the bus
    // reads as zero everywhere else.
    always_ff @(posedge OPB_CLK) begin
        if (OPB_RST) begin
            r_state    <= S_IDLE;
            r_grant    <= 1'b0;
            r_last     <= 1'b1;
            r_cmd_rnw  <= 1'b0;
            r_opb_re   <= 1'b0;
            r_opb_we   <= 1'b0;
            r_opb_addr <= '0;
            r_opb_di   <= '0;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
`ifdef OPB_ARB_LOCK_EN
            r_locked   <= 1'b0;
            r_lock_own <= 1'b0;
`endif
        end else begin
            r_opb_re   <= 1'b0;
            r_opb_we   <= 1'b0;
            r_opb_addr <= '0;
            r_opb_di   <= '0;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
            case (r_state)
                S_IDLE: begin
`ifdef OPB_ARB_LOCK_EN
                    if (r_locked && !w_owner_lock) begin
                        r_locked <= 1'b0;
                    end
`endif
                    if (w_any) begin
                        r_grant    <= w_win;
                        r_cmd_rnw  <= w_sel_rnw;
                        r_opb_re   <= w_sel_rnw;
                        r_opb_we   <= ~w_sel_rnw;
                        r_opb_addr <= w_sel_addr;
                        r_opb_di   <= w_sel_wdata;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_cmd_rnw) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        // Write completes without waiting on the decoder
                        r_m0_ack <= ~r_grant;
                        r_m1_ack <= r_grant;
                        r_state  <= S_DONE;
                    end
                end
                S_CAPTURE: begin
                    // Decoder read data is valid exactly one cycle after OPB_RE
                    if (r_grant) begin
                        r_m1_rdata <= OPB_DO;
                    end else begin
                        r_m0_rdata <= OPB_DO;
                    end
                    r_m0_ack <= ~r_grant;
                    r_m1_ack <= r_grant;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_last <= r_grant;
`ifdef OPB_ARB_LOCK_EN
                    if (w_grant_lock) begin
                        r_locked   <= 1'b1;
                        r_lock_own <= r_grant;
                    end
`endif
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign OPB_RE   = r_opb_re;
    assign OPB_WE   = r_opb_we;
    assign OPB_ADDR = r_opb_addr;
    assign OPB_DI   = r_opb_di;
    assign M0_ACK   = r_m0_ack;
    assign M1_ACK   = r_m1_ack;
    assign M0_RDATA = r_m0_rdata;
    assign M1_RDATA = r_m1_rdata;
    assign BUSY     = (r_state != S_IDLE);
    assign GRANT_ID = r_grant;

endmodule

// File: tb/tb_opb_master_arbiter.sv
// Purpose : randomized and scripted stimulus for opb_master_arbiter, checked every cycle against a transaction-level model.
// Latency : model predicts strobe/ACK edges from the grant edge with plain arithmetic.
// Backpr. : bench requesters hold REQ until ACK and may repost on the ACK edge.

module tb_opb_master_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic          rnw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          lock;
    } txn_t;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [1:0]    req;
    logic [1:0]    rnw;
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic [DW-1:0] opb_do;
`ifdef OPB_ARB_LOCK_EN
    logic [1:0]    lock;
`endif

    logic          m0_ack, m1_ack, opb_re, opb_we, busy, grant_id;
    logic [DW-1:0] m0_rdata, m1_rdata, opb_di;
    logic [AW-1:0] opb_addr;

    opb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .OPB_CLK (clk),
        .OPB_RST (rst),
        .M0_REQ  (req[0]),
        .M0_RNW  (rnw[0]),
        .M0_ADDR (addr[0]),
        .M0_WDATA(wdata[0]),
        .M0_ACK  (m0_ack),
        .M0_RDATA(m0_rdata),
        .M1_REQ  (req[1]),
        .M1_RNW  (rnw[1]),
        .M1_ADDR (addr[1]),
        .M1_WDATA(wdata[1]),
        .M1_ACK  (m1_ack),
        .M1_RDATA(m1_rdata),
`ifdef OPB_ARB_LOCK_EN
        .M0_LOCK (lock[0]),
        .M1_LOCK (lock[1]),
`endif
        .OPB_RE  (opb_re),
        .OPB_WE  (opb_we),
        .OPB_ADDR(opb_addr),
        .OPB_DI  (opb_di),
        .OPB_DO  (opb_do),
        .BUSY    (busy),
        .GRANT_ID(grant_id)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- requesters ----------------
    txn_t q0[$];
    txn_t q1[$];
    txn_t cur [2];
    bit   active [2];
    bit   scramble    = 0;
    bit   rnd_rst     = 0;
    bit   force_rst   = 1;
    bit   cap_rst     = 0;
    bit   do_fixed_en = 0;
    logic [DW-1:0] do_fixed = '0;
    logic obs[$];   // GRANT_ID seen at each bus strobe

    task automatic push_txn(input int m, input logic r, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic l);
        txn_t t;
        t.rnw = r; t.addr = a; t.wdata = d; t.lock = l;
        if (m == 0) q0.push_back(t); else q1.push_back(t);
    endtask

    task automatic pop_txn(input int m, output txn_t t, output bit ok);
        ok = 0;
        t  = '0;
        if (m == 0 && q0.size() > 0) begin t = q0.pop_front(); ok = 1; end
        if (m == 1 && q1.size() > 0) begin t = q1.pop_front(); ok = 1; end
    endtask

    // ---------------- reference model ----------------
    int            n = 0;            // index of the most recent rising edge
    bit            m_pending = 0;
    int            m_grant_edge, m_ack_edge;
    int            m_idle_from = 0;
    bit            m_win, m_last = 1, m_gid = 0;
    txn_t          m_cmd;
    logic [DW-1:0] m_rdata [2];
    bit            m_lock = 0, m_lock_own = 0;

    task automatic model_edge(input bit s_rst, input logic [1:0] s_req,
                              input logic [1:0] s_lock, input logic [DW-1:0] s_do,
                              input txn_t s_cmd0, input txn_t s_cmd1);
        logic [1:0] cand;
        if (s_rst) begin
            m_pending   = 0;
            m_last      = 1;
            m_gid       = 0;
            m_rdata[0]  = '0;
            m_rdata[1]  = '0;
            m_lock      = 0;
            m_idle_from = n + 1;
            return;
        end
        if (m_pending && m_cmd.rnw && n == m_ack_edge) m_rdata[m_win] = s_do;
        if (m_pending && n == m_ack_edge + 1) begin
            m_last    = m_win;
            m_pending = 0;
            if (s_lock[m_win]) begin m_lock = 1; m_lock_own = m_win; end
        end
        if (!m_pending && n >= m_idle_from) begin
            cand = s_req;
            if (m_lock) begin
                if (s_lock[m_lock_own]) cand = s_req & (m_lock_own ? 2'b10 : 2'b01);
                else m_lock = 0;
            end
            if (cand != 2'b00) begin
                m_win        = (cand == 2'b11) ? !m_last : cand[1];
                m_cmd        = m_win ? s_cmd1 : s_cmd0;
                m_gid        = m_win;
                m_pending    = 1;
                m_grant_edge = n;
                m_ack_edge   = n + (m_cmd.rnw ? 2 : 1);
                m_idle_from  = m_ack_edge + 2;
            end
        end
    endtask

    task automatic step();
        txn_t       s_cmd0, s_cmd1, t;
        logic [1:0] s_lock;
        bit         strobe, ok;
        logic       a;
        @(posedge clk);
        #1;
        n++;
        s_cmd0 = '{rnw: rnw[0], addr: addr[0], wdata: wdata[0], lock: 1'b0};
        s_cmd1 = '{rnw: rnw[1], addr: addr[1], wdata: wdata[1], lock: 1'b0};
`ifdef OPB_ARB_LOCK_EN
        s_lock = lock;
`else
        s_lock = 2'b00;
`endif
        model_edge(rst, req, s_lock, opb_do, s_cmd0, s_cmd1);

        strobe = m_pending && (n == m_grant_edge);
        chk("opb_re",   opb_re,   strobe && m_cmd.rnw);
        chk("opb_we",   opb_we,   strobe && !m_cmd.rnw);
        chk("opb_addr", opb_addr, strobe ? m_cmd.addr  : '0);
        chk("opb_di",   opb_di,   strobe ? m_cmd.wdata : '0);
        chk("m0_ack",   m0_ack,   m_pending && n == m_ack_edge && m_win == 0);
        chk("m1_ack",   m1_ack,   m_pending && n == m_ack_edge && m_win == 1);
        chk("busy",     busy,     m_pending);
        chk("grant_id", grant_id, m_gid);
        chk("m0_rdata", m0_rdata, m_rdata[0]);
        chk("m1_rdata", m1_rdata, m_rdata[1]);
        if (opb_re || opb_we) obs.push_back(grant_id);

        // drive inputs for the next edge
        rst = force_rst || (rnd_rst && $urandom_range(0, 149) == 0);
        if (cap_rst && m_pending && m_cmd.rnw && n == m_grant_edge + 1) begin
            rst     = 1;      // sampled on the edge that ends CAPTURE
            cap_rst = 0;
            obs.delete();
            push_txn(0, 1'b0, 32'h0000_0300, 32'hA5A5_5A5A, 1'b0);
        end
        for (int m = 0; m < 2; m++) begin
            a = (m == 0) ? m0_ack : m1_ack;
            if (active[m] && a) begin
                // LOCK is left as-is on the ACK edge so it covers the DONE cycle
                pop_txn(m, t, ok);
                if (ok) cur[m] = t; else active[m] = 0;
            end else begin
                if (!active[m]) begin
                    pop_txn(m, t, ok);
                    if (ok) begin cur[m] = t; active[m] = 1; end
                end
`ifdef OPB_ARB_LOCK_EN
                lock[m] = active[m] ? cur[m].lock : 1'b0;
`endif
            end
            if (scramble && active[m] && $urandom_range(0, 3) == 0) begin
                cur[m].rnw   = 1'($urandom_range(0, 1));
                cur[m].addr  = $urandom;
                cur[m].wdata = $urandom;
            end
            req[m]   = active[m];
            rnw[m]   = cur[m].rnw;
            addr[m]  = cur[m].addr;
            wdata[m] = cur[m].wdata;
        end
        opb_do = do_fixed_en ? do_fixed : $urandom;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    function automatic logic [7:0] obs_bits();
        logic [7:0] v = '0;
        for (int i = 0; i < obs.size() && i < 8; i++) v[i] = obs[i];
        return v;
    endfunction

    initial begin
        rst    = 1;
        req    = '0;
        rnw    = '0;
        opb_do = '0;
        for (int m = 0; m < 2; m++) begin
            addr[m] = '0; wdata[m] = '0; active[m] = 0; cur[m] = '0;
            m_rdata[m] = '0;
        end
`ifdef OPB_ARB_LOCK_EN
        lock = '0;
`endif
        run(2);
        force_rst = 0;
        run(2);

        // single M0 write
        push_txn(0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
        run(6);

        // single M1 read with fixed decoder data
        do_fixed_en = 1;
        do_fixed    = 32'h1234_5678;
        push_txn(1, 1'b1, 32'h0000_0200, 32'h0, 1'b0);
        run(7);
        chk("m1_rdata_read", m1_rdata, 32'h1234_5678);
        do_fixed_en = 0;

        // both masters held for four transactions
        obs.delete();
        push_txn(0, 1'b0, 32'h10, 32'h1, 1'b0);
        push_txn(0, 1'b1, 32'h14, 32'h2, 1'b0);
        push_txn(1, 1'b0, 32'h20, 32'h3, 1'b0);
        push_txn(1, 1'b1, 32'h24, 32'h4, 1'b0);
        run(18);
        chk("rr_count", obs.size(), 4);
        chk("rr_order", obs_bits(), 8'b0000_1010);

        // back-to-back M0 writes
        for (int i = 0; i < 3; i++) push_txn(0, 1'b0, 32'h40 + i, $urandom, 1'b0);
        run(14);

        // reset while a read is in CAPTURE, then a tie
        cap_rst = 1;
        push_txn(1, 1'b1, 32'h0000_0280, 32'h0, 1'b0);
        run(16);
        chk("rst_count", obs.size(), 2);
        chk("rst_order", obs_bits(), 8'b0000_0010);

        // M1 locked read-then-write against continuous M0 requests
        obs.delete();
        push_txn(1, 1'b1, 32'h0000_0500, 32'h0, 1'b1);
        push_txn(1, 1'b0, 32'h0000_0500, 32'h55, 1'b1);
        run(1);
        push_txn(0, 1'b0, 32'h0000_0600, 32'h66, 1'b0);
        push_txn(0, 1'b0, 32'h0000_0604, 32'h67, 1'b0);
        run(20);
        chk("lock_count", obs.size(), 4);
`ifdef OPB_ARB_LOCK_EN
        chk("lock_order", obs_bits(), 8'b0000_0011);
`else
        chk("lock_order", obs_bits(), 8'b0000_0101);
`endif

        // randomized traffic with command changes while waiting and random resets
        scramble = 1;
        rnd_rst  = 1;
        for (int i = 0; i < 3000; i++) begin
            for (int m = 0; m < 2; m++) begin
                if ((m == 0 ? q0.size() : q1.size()) == 0 && $urandom_range(0, 2) == 0)
                    push_txn(m, 1'($urandom_range(0, 1)), $urandom, $urandom,
                             1'($urandom_range(0, 3) == 0));
            end
            step();
        end
        scramble = 0;
        rnd_rst  = 0;
        run(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
